// File: rtl/uart_pkg.sv
// Shared UART types and limits used by the receive path and its helpers.
package uart_pkg;

    localparam int UART_MIN_DATA_W  = 5;
    localparam int UART_MIN_BIT_LEN = 4;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD,
        PAR_NONE2
    } parity_mode_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP1,
        RX_STOP2,
        RX_WAIT_IDLE
    } rx_state_t;

    function automatic logic parity_enabled(input parity_mode_t m);
        return (m == PAR_EVEN) || (m == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for an asynchronous, idle-high serial line.
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_nrst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx_ovs.sv
// UART receiver: configurable frame format, 3-sample mid-bit majority vote,
// false-start rejection, break detection and a one-cycle completion strobe.
module uart_rx_ovs
    import uart_pkg::*;
#(
    parameter int MAX_DATA_W  = 9,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_enable,
    input  logic [CNT_W-1:0]      i_bit_length,
    input  logic [3:0]            i_data_width,
    input  logic [1:0]            i_parity_mode,
    input  logic [1:0]            i_stop_bit_mode,
    input  logic                  i_msb_first,
    input  logic                  i_rx,
    output logic                  o_rx_valid,
    output logic [MAX_DATA_W-1:0] o_rx_data,
    output logic                  o_rx_parity_error,
    output logic                  o_rx_frame_error,
    output logic                  o_rx_break,
    output logic                  o_rx_busy,
    output logic                  o_rx_started
);

    localparam logic [3:0]       MAX_W   = 4'(MAX_DATA_W);
    localparam logic [3:0]       MIN_W   = 4'(UART_MIN_DATA_W);
    localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(UART_MIN_BIT_LEN);

    logic rx_s;

    uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .i_clk  (i_clk),
        .i_nrst (i_nrst),
        .i_d    (i_rx),
        .o_q    (rx_s)
    );

    rx_state_t             state;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      len;
    logic [3:0]            width;
    logic [3:0]            bit_k;
    parity_mode_t          par_mode;
    logic                  stop2;
    logic                  msb_first;
    logic                  samp_a;
    logic                  samp_b;
    logic                  par_err;
    logic                  frame_err;
    logic                  all_zero;
    logic [MAX_DATA_W-1:0] data;

    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] len_in;
    logic [3:0]       width_in;
    logic [3:0]       idx;
    logic             decide;
    logic             wrap;
    logic             maj;
    logic             par_exp;
    logic             finish;

    assign half     = len >> 1;
    assign decide   = (cnt == half);
    assign wrap     = (cnt == len - CNT_W'(1));
    assign maj      = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
    assign idx      = msb_first ? (width - 4'd1 - bit_k) : bit_k;
    assign par_exp  = (par_mode == PAR_ODD) ? ~(^data) : ^data;
    assign len_in   = (i_bit_length < MIN_LEN) ? MIN_LEN : i_bit_length;
    assign width_in = (i_data_width < MIN_W) ? MIN_W :
                      (i_data_width > MAX_W) ? MAX_W : i_data_width;
    assign finish   = decide && ((state == RX_STOP2) || (state == RX_STOP1 && !stop2));
    assign o_rx_busy = (state != RX_IDLE);

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state             <= RX_IDLE;
            cnt               <= '0;
            len               <= '0;
            width             <= '0;
            bit_k             <= '0;
            par_mode          <= PAR_NONE;
            stop2             <= 1'b0;
            msb_first         <= 1'b0;
            samp_a            <= 1'b1;
            samp_b            <= 1'b1;
            par_err           <= 1'b0;
            frame_err         <= 1'b0;
            all_zero          <= 1'b0;
            data              <= '0;
            o_rx_valid        <= 1'b0;
            o_rx_data         <= '0;
            o_rx_parity_error <= 1'b0;
            o_rx_frame_error  <= 1'b0;
            o_rx_break        <= 1'b0;
            o_rx_started      <= 1'b0;
        end else begin
            o_rx_valid   <= 1'b0;
            o_rx_started <= 1'b0;

            if (state != RX_IDLE) begin
                cnt <= wrap ? '0 : cnt + CNT_W'(1);
                if (cnt == half - CNT_W'(2)) samp_a <= rx_s;
                if (cnt == half - CNT_W'(1)) samp_b <= rx_s;
            end

            if (!i_enable) begin
                state <= RX_IDLE;
            end else begin
                case (state)
                    RX_IDLE: begin
                        if (!rx_s) begin
                            state     <= RX_START;
                            cnt       <= '0;
                            len       <= len_in;
                            width     <= width_in;
                            par_mode  <= parity_mode_t'(i_parity_mode);
                            stop2     <= (i_stop_bit_mode == 2'd1);
                            msb_first <= i_msb_first;
                            bit_k     <= '0;
                            data      <= '0;
                            par_err   <= 1'b0;
                            frame_err <= 1'b0;
                            all_zero  <= 1'b1;
                        end
                    end
                    RX_START: begin
                        if (decide) begin
                            if (maj) state <= RX_IDLE;
                            else     o_rx_started <= 1'b1;
                        end
                        if (wrap) state <= RX_DATA;
                    end
                    RX_DATA: begin
                        if (decide) begin
                            data[idx] <= maj;
                            if (maj) all_zero <= 1'b0;
                        end
                        if (wrap) begin
                            if (bit_k == width - 4'd1) begin
                                bit_k <= '0;
                                state <= parity_enabled(par_mode) ? RX_PARITY : RX_STOP1;
                            end else begin
                                bit_k <= bit_k + 4'd1;
                            end
                        end
                    end
                    RX_PARITY: begin
                        if (decide) begin
                            if (maj != par_exp) par_err <= 1'b1;
                            if (maj) all_zero <= 1'b0;
                        end
                        if (wrap) state <= RX_STOP1;
                    end
                    RX_STOP1, RX_STOP2: begin
                        // Stop 1 folds into frame_err/all_zero; stop 2 only adds to the frame error.
                        if (decide && state == RX_STOP1) begin
                            frame_err <= !maj;
                            all_zero  <= all_zero & !maj;
                        end
                        if (finish) begin
                            o_rx_valid        <= 1'b1;
                            o_rx_data         <= data;
                            o_rx_parity_error <= par_err;
                            o_rx_frame_error  <= frame_err | !maj;
                            o_rx_break        <= (state == RX_STOP1) ? (all_zero & !maj) : all_zero;
                            state             <= maj ? RX_IDLE : RX_WAIT_IDLE;
                        end else if (wrap && state == RX_STOP1) begin
                            state <= RX_STOP2;
                        end
                    end
                    RX_WAIT_IDLE: begin
                        if (rx_s) state <= RX_IDLE;
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Self-checking bench for uart_rx_ovs: frames are built as line-level lists and
// decoded by a reference model into expected data, flags and strobe latency.
module tb_uart_rx_ovs;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        en = 1'b0;
    logic        rx = 1'b1;
    logic [31:0] bl = 32'd16;
    logic [3:0]  dw = 4'd8;
    logic [1:0]  pm = 2'd0;
    logic [1:0]  sm = 2'd0;
    logic        msb = 1'b0;

    logic       valid, pe, fe, brk, busy, started;
    logic [8:0] data;

    uart_rx_ovs #(.MAX_DATA_W(9), .CNT_W(32), .SYNC_STAGES(2)) dut (
        .i_clk             (clk),
        .i_nrst            (nrst),
        .i_enable          (en),
        .i_bit_length      (bl),
        .i_data_width      (dw),
        .i_parity_mode     (pm),
        .i_stop_bit_mode   (sm),
        .i_msb_first       (msb),
        .i_rx              (rx),
        .o_rx_valid        (valid),
        .o_rx_data         (data),
        .o_rx_parity_error (pe),
        .o_rx_frame_error  (fe),
        .o_rx_break        (brk),
        .o_rx_busy         (busy),
        .o_rx_started      (started)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] data;
        logic       pe;
        logic       fe;
        logic       brk;
        int         cyc;
    } rec_t;

    int   n_checks = 0;
    int   n_fail = 0;
    rec_t vq[$];
    int   sq[$];
    int   started_cnt = 0;
    int   cyc = 0;
    logic busy_d = 1'b0;
    bit   lv[$];
    int   Le, We, Pe, S2, pm_e;
    bit   msb_e;

    // Monitor: strobe records, first-START cycles and start pulses.
    always @(negedge clk) begin
        cyc++;
        if (nrst) begin
            if (busy && !busy_d) sq.push_back(cyc);
            if (valid) vq.push_back('{data: data, pe: pe, fe: fe, brk: brk, cyc: cyc});
            if (started) started_cnt++;
        end
        busy_d = busy;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        vq.delete();
        sq.delete();
        started_cnt = 0;
    endtask

    task automatic set_cfg(input int b, input int w, input int p, input int s, input bit m);
        bl    = 32'(b);
        dw    = 4'(w);
        pm    = 2'(p);
        sm    = 2'(s);
        msb   = m;
        Le    = (b < 4) ? 4 : b;
        We    = (w < 5) ? 5 : ((w > 9) ? 9 : w);
        Pe    = (p == 1 || p == 2) ? 1 : 0;
        S2    = (s == 1) ? 1 : 0;
        pm_e  = p;
        msb_e = m;
    endtask

    task automatic build(input logic [8:0] d, input bit flip_par, input bit flip_stop1);
        bit p;
        p = 1'b0;
        lv.delete();
        lv.push_back(1'b0);
        for (int i = 0; i < We; i++) begin
            bit b;
            b = d[msb_e ? We - 1 - i : i];
            lv.push_back(b);
            p ^= b;
        end
        if (Pe == 1) lv.push_back(((pm_e == 2) ? ~p : p) ^ flip_par);
        lv.push_back(~flip_stop1);
        if (S2 == 1) lv.push_back(1'b1);
    endtask

    // Decode the line levels of one frame the way a receiver should see them.
    function automatic rec_t ref_model();
        rec_t r;
        int   v;
        bit   allz, pb, s1, s2b;
        v    = 0;
        allz = 1'b1;
        for (int i = 0; i < We; i++) begin
            if (lv[1 + i]) begin
                allz = 1'b0;
                v |= 1 << (msb_e ? We - 1 - i : i);
            end
        end
        r.data = v[8:0];
        pb = (Pe == 1) ? lv[1 + We] : 1'b0;
        if (pb) allz = 1'b0;
        r.pe = (Pe == 1) && (pb != ((pm_e == 2) ? ~(^r.data) : ^r.data));
        s1   = lv[1 + We + Pe];
        s2b  = (S2 == 1) ? lv[2 + We + Pe] : 1'b1;
        r.fe  = !s1 || !s2b;
        r.brk = allz && !s1;
        r.cyc = (1 + We + Pe + S2) * Le + Le / 2 + 1;
        return r;
    endfunction

    task automatic drive(input int g, input int nb);
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < Le; j++) begin
                rx = (b == g && j == Le / 2 - 1) ? ~lv[b] : lv[b];
                @(negedge clk);
            end
        end
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    function automatic rec_t get_rec(input int i);
        rec_t r;
        r = '{data: 'x, pe: 'x, fe: 'x, brk: 'x, cyc: -1000000};
        if (i < vq.size()) r = vq[i];
        return r;
    endfunction

    function automatic int get_start(input int i);
        return (i < sq.size()) ? sq[i] : 0;
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({valid, data, pe, fe, brk, busy, started} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h expected 0", {valid, data, pe, fe, brk, busy, started});
        end
        nrst = 1'b1;
        en   = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({valid, data, pe, fe, brk, busy, started} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected 0", {valid, data, pe, fe, brk, busy, started});
        end
    endtask

    task automatic test_8n1();
        rec_t e, r;
        set_cfg(16, 8, 0, 0, 0);
        clear_mon();
        build(9'h0A5, 1'b0, 1'b0);
        e = ref_model();
        drive(-1, lv.size());
        idle(Le + 6);
        r = get_rec(0);
        n_checks++;
        if (vq.size() != 1) begin n_fail++; $display("FAIL 8n1_count: got %0d strobes expected 1", vq.size()); end
        n_checks++;
        if (started_cnt != 1) begin n_fail++; $display("FAIL 8n1_started: got %0d pulses expected 1", started_cnt); end
        n_checks++;
        if ({r.data, r.pe, r.fe, r.brk} !== {9'h0A5, 3'b000}) begin
            n_fail++; $display("FAIL 8n1_frame: got %h expected %h", {r.data, r.pe, r.fe, r.brk}, {9'h0A5, 3'b000});
        end
        n_checks++;
        if (r.cyc - get_start(0) !== 153) begin
            n_fail++; $display("FAIL 8n1_latency: got %0d expected 153 (model %0d)", r.cyc - get_start(0), e.cyc);
        end
    endtask

    task automatic test_7e2_parity();
        rec_t e, r;
        set_cfg(10, 7, 1, 1, 1);
        clear_mon();
        build(9'h05A, 1'b1, 1'b0);
        e = ref_model();
        drive(-1, lv.size());
        idle(Le + 6);
        r = get_rec(0);
        n_checks++;
        if (vq.size() != 1) begin n_fail++; $display("FAIL 7e2_count: got %0d expected 1", vq.size()); end
        n_checks++;
        if ({r.data, r.pe, r.fe, r.brk} !== {9'h05A, 3'b100}) begin
            n_fail++; $display("FAIL 7e2_frame: got %h expected %h", {r.data, r.pe, r.fe, r.brk}, {9'h05A, 3'b100});
        end
        n_checks++;
        if (r.cyc - get_start(0) !== e.cyc) begin
            n_fail++; $display("FAIL 7e2_latency: got %0d expected %0d", r.cyc - get_start(0), e.cyc);
        end
    endtask

    task automatic test_glitch();
        rec_t e, r;
        set_cfg(16, 8, 0, 0, 0);
        clear_mon();
        rx = 1'b0;
        repeat (3) @(negedge clk);
        idle(3 * Le);
        n_checks++;
        if (started_cnt != 0) begin n_fail++; $display("FAIL glitch_started: got %0d expected 0", started_cnt); end
        n_checks++;
        if (vq.size() != 0) begin n_fail++; $display("FAIL glitch_valid: got %0d expected 0", vq.size()); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: busy got %b expected 0", busy); end
        clear_mon();
        build(9'h03C, 1'b0, 1'b0);
        e = ref_model();
        drive(1, lv.size());
        idle(Le + 6);
        r = get_rec(0);
        n_checks++;
        if (vq.size() != 1) begin n_fail++; $display("FAIL vote_count: got %0d expected 1", vq.size()); end
        n_checks++;
        if ({r.data, r.pe, r.fe, r.brk} !== {e.data, e.pe, e.fe, e.brk}) begin
            n_fail++; $display("FAIL vote_frame: got %h expected %h", {r.data, r.pe, r.fe, r.brk}, {e.data, e.pe, e.fe, e.brk});
        end
        n_checks++;
        if (r.cyc - get_start(0) !== e.cyc) begin
            n_fail++; $display("FAIL vote_latency: got %0d expected %0d", r.cyc - get_start(0), e.cyc);
        end
    endtask

    task automatic test_break();
        rec_t e, r;
        set_cfg(16, 8, 0, 0, 0);
        clear_mon();
        lv.delete();
        repeat (10) lv.push_back(1'b0);
        e = ref_model();
        rx = 1'b0;
        repeat (20 * Le) @(negedge clk);
        r = get_rec(0);
        n_checks++;
        if (vq.size() != 1) begin n_fail++; $display("FAIL break_count: got %0d expected 1", vq.size()); end
        n_checks++;
        if ({r.data, r.pe, r.fe, r.brk} !== {9'h000, 3'b011}) begin
            n_fail++; $display("FAIL break_frame: got %h expected %h", {r.data, r.pe, r.fe, r.brk}, {9'h000, 3'b011});
        end
        n_checks++;
        if (r.cyc - get_start(0) !== e.cyc) begin
            n_fail++; $display("FAIL break_latency: got %0d expected %0d", r.cyc - get_start(0), e.cyc);
        end
        idle(2 * Le);
        n_checks++;
        if (vq.size() != 1) begin n_fail++; $display("FAIL break_retrigger: got %0d strobes expected 1", vq.size()); end
        clear_mon();
        build(9'h03C, 1'b0, 1'b0);
        e = ref_model();
        drive(-1, lv.size());
        idle(Le + 6);
        r = get_rec(0);
        n_checks++;
        if (vq.size() != 1 || {r.data, r.pe, r.fe, r.brk} !== {9'h03C, 3'b000}) begin
            n_fail++; $display("FAIL after_break_frame: got %0d strobes, %h expected 1, %h", vq.size(), {r.data, r.pe, r.fe, r.brk}, {9'h03C, 3'b000});
        end
    endtask

    task automatic test_enable_abort();
        rec_t e, r;
        set_cfg(16, 8, 0, 0, 0);
        clear_mon();
        build(9'h000, 1'b0, 1'b0);
        drive(-1, 4);
        rx = 1'b0;
        en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: busy got %b expected 0", busy); end
        idle(3 * Le);
        n_checks++;
        if (vq.size() != 0) begin n_fail++; $display("FAIL abort_strobe: got %0d expected 0", vq.size()); end
        en = 1'b1;
        idle(4);
        clear_mon();
        build(9'h0FF, 1'b0, 1'b0);
        e = ref_model();
        drive(-1, lv.size());
        idle(Le + 6);
        r = get_rec(0);
        n_checks++;
        if (vq.size() != 1 || {r.data, r.pe, r.fe, r.brk} !== {9'h0FF, 3'b000}) begin
            n_fail++; $display("FAIL abort_next_frame: got %0d strobes, %h expected 1, %h", vq.size(), {r.data, r.pe, r.fe, r.brk}, {9'h0FF, 3'b000});
        end
        n_checks++;
        if (r.cyc - get_start(0) !== e.cyc) begin
            n_fail++; $display("FAIL abort_latency: got %0d expected %0d", r.cyc - get_start(0), e.cyc);
        end
    endtask

    task automatic test_9o_clamp();
        rec_t r;
        set_cfg(2, 9, 2, 0, 0);
        clear_mon();
        build(9'h1FF, 1'b0, 1'b0);
        drive(-1, lv.size());
        idle(Le + 6);
        r = get_rec(0);
        n_checks++;
        if (vq.size() != 1) begin n_fail++; $display("FAIL 9o_count: got %0d expected 1", vq.size()); end
        n_checks++;
        if ({r.data, r.pe, r.fe, r.brk} !== {9'h1FF, 3'b000}) begin
            n_fail++; $display("FAIL 9o_frame: got %h expected %h", {r.data, r.pe, r.fe, r.brk}, {9'h1FF, 3'b000});
        end
        n_checks++;
        if (r.cyc - get_start(0) !== 47) begin
            n_fail++; $display("FAIL 9o_latency: got %0d expected 47", r.cyc - get_start(0));
        end
    endtask

    task automatic test_async_reset();
        set_cfg(16, 8, 0, 0, 0);
        clear_mon();
        build(9'h055, 1'b0, 1'b0);
        drive(-1, 5);
        #2 nrst = 1'b0;
        #1;
        n_checks++;
        if ({valid, data, pe, fe, brk, busy, started} !== 15'd0) begin
            n_fail++; $display("FAIL async_reset: got %h expected 0", {valid, data, pe, fe, brk, busy, started});
        end
        rx = 1'b1;
        @(negedge clk);
        nrst = 1'b1;
        idle(3 * Le);
        n_checks++;
        if (vq.size() != 0) begin n_fail++; $display("FAIL async_reset_strobe: got %0d expected 0", vq.size()); end
    endtask

    task automatic test_random();
        rec_t e, r;
        for (int f = 0; f < 12; f++) begin
            set_cfg($urandom_range(0, 20), $urandom_range(3, 12), $urandom_range(0, 3),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            clear_mon();
            build(9'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
            e = ref_model();
            drive(-1, lv.size());
            idle(Le + 6);
            r = get_rec(0);
            n_checks++;
            if (vq.size() != 1) begin n_fail++; $display("FAIL random%0d_count: got %0d expected 1", f, vq.size()); end
            n_checks++;
            if ({r.data, r.pe, r.fe, r.brk} !== {e.data, e.pe, e.fe, e.brk}) begin
                n_fail++; $display("FAIL random%0d_frame: got %h expected %h (L=%0d W=%0d pm=%0d s2=%0d msb=%0d)",
                                   f, {r.data, r.pe, r.fe, r.brk}, {e.data, e.pe, e.fe, e.brk}, Le, We, pm_e, S2, msb_e);
            end
            n_checks++;
            if (r.cyc - get_start(0) !== e.cyc) begin
                n_fail++; $display("FAIL random%0d_latency: got %0d expected %0d", f, r.cyc - get_start(0), e.cyc);
            end
        end
    endtask

    task automatic test_back_to_back();
        rec_t eq[$];
        rec_t r;
        set_cfg($urandom_range(4, 12), $urandom_range(5, 9), $urandom_range(0, 3),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        clear_mon();
        for (int f = 0; f < 5; f++) begin
            build(9'($urandom), $urandom_range(0, 2) == 0, 1'b0);
            eq.push_back(ref_model());
            drive(-1, lv.size());
        end
        idle(Le + 6);
        n_checks++;
        if (vq.size() != 5) begin n_fail++; $display("FAIL b2b_count: got %0d expected 5", vq.size()); end
        for (int f = 0; f < 5; f++) begin
            r = get_rec(f);
            n_checks++;
            if ({r.data, r.pe, r.fe, r.brk} !== {eq[f].data, eq[f].pe, eq[f].fe, eq[f].brk}) begin
                n_fail++; $display("FAIL b2b%0d_frame: got %h expected %h", f, {r.data, r.pe, r.fe, r.brk},
                                   {eq[f].data, eq[f].pe, eq[f].fe, eq[f].brk});
            end
            n_checks++;
            if (r.cyc - get_start(f) !== eq[f].cyc) begin
                n_fail++; $display("FAIL b2b%0d_latency: got %0d expected %0d", f, r.cyc - get_start(f), eq[f].cyc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_7e2_parity();
        test_glitch();
        test_break();
        test_enable_abort();
        test_9o_clamp();
        test_async_reset();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_ovs.md
Name: uart_rx_ovs

Overview:
Second-generation UART receiver with runtime-configurable frame format: 5..MAX_DATA_W data bits, none/even/odd parity, 1 or 2 stop bits, LSB- or MSB-first.
- Adds an input synchroniser, 3-sample majority voting at mid-bit, false-start rejection, break detection and a one-cycle valid strobe.
- Sits between the pad-side RX line and the RX FIFO / register block of the UART top.

Parameters:
MAX_DATA_W, 9, maximum data bits per frame; sets the o_rx_data width.
CNT_W, 32, width of the bit-timer and of i_bit_length.
SYNC_STAGES, 2, flops in the i_rx synchroniser (minimum 2).

Ports:
i_clk  in  1  clock
i_nrst  in  1  reset; asynchronous, active-low
i_enable  in  1  receiver enable; low = abort to IDLE
i_bit_length  in  CNT_W  clocks per bit; values below 4 are treated as 4
i_data_width  in  4  data bits per frame; below 5 clamps to 5, above MAX_DATA_W clamps to MAX_DATA_W
i_parity_mode  in  2  0 none, 1 even, 2 odd, 3 none
i_stop_bit_mode  in  2  1 = two stop bits, otherwise one
i_msb_first  in  1  1 = first data bit received is the MSB
i_rx  in  1  serial line, asynchronous
o_rx_valid  out  1  one-cycle strobe: frame complete
o_rx_data  out  MAX_DATA_W  received data, right-justified, unused MSBs 0
o_rx_parity_error  out  1  qualified by o_rx_valid
o_rx_frame_error  out  1  qualified by o_rx_valid
o_rx_break  out  1  qualified by o_rx_valid
o_rx_busy  out  1  high in every state except IDLE
o_rx_started  out  1  one-cycle pulse on start-bit validation

Behaviour:
- Reset:
  - all outputs 0; synchroniser flops 1; state IDLE.
  - o_rx_data, error flags and o_rx_break hold their values until the next o_rx_valid.
- Synchronisation:
  - i_rx passes through SYNC_STAGES flops to give rx_s.
  - All timing below refers to rx_s.
- Bit timer and sampling:
  - Bit timer runs 0..L-1, where L = max(i_bit_length, 4); H = L>>1.
  - Bit value = majority of rx_s at counts H-2, H-1 and H.
  - Decision is made at count H.
  - Timer wraps to 0 at count L-1.
- Configuration: L, data width, parity mode, stop mode and msb_first are latched on the IDLE->START transition and remain constant for the frame.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_IDLE.
  - IDLE: when i_enable=1 and rx_s=0, go to START with timer=0.
  - START:
    - at decision, majority 1 -> IDLE (false start, no strobe, no flags);
    - majority 0 -> o_rx_started pulses next cycle;
    - at wrap, go to DATA.
  - DATA:
    - store each decided bit at index k (LSB-first) or W-1-k (MSB-first), where W is the latched width and k counts 0..W-1.
    - after bit W-1 wraps: go to PARITY if parity is enabled, else STOP1.
  - PARITY:
    - expected bit = XOR(data) for even, ~XOR(data) for odd.
    - a mismatch sets the internal parity error.
  - STOP1:
    - at decision, a sampled 0 sets the internal frame error.
    - for one stop bit, the frame completes at this decision; there is no wait for wrap.
    - for two stop bits, go to STOP2 at wrap.
  - STOP2: the same check; the frame completes at its decision.
  - Completion:
    - o_rx_valid=1 for one cycle (registered, one cycle after the decision).
    - o_rx_data and the flags update in that same cycle.
    - next state: IDLE if the final stop sample was 1, else WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then go to IDLE. This prevents a stuck-low line from retriggering.
- Break: o_rx_break=1 when every data bit, the parity bit (if enabled) and stop bit 1 were sampled 0. o_rx_frame_error is also 1 in that case.
- Latency: for one stop bit, o_rx_valid is high exactly (1+W+P)*L + H + 1 cycles after the first START cycle, where P = 1 if parity is enabled, else 0.
- i_enable=0 in any state: go to IDLE the next cycle; no strobe; outputs hold their values.
- Asynchronous reset mid-frame: returns the block to the reset state immediately; no strobe is produced.
- Back-to-back frames: a start edge found in IDLE on the cycle after completion is accepted. No dead cycles are required beyond this.

Decomposition:
- Add to uart_pkg:
  - parity_mode_t enum {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_NONE2};
  - rx_state_t enum;
  - UART_MIN_DATA_W = 5;
  - UART_MIN_BIT_LEN = 4.
- Sub-module uart_sync: a SYNC_STAGES-deep flop chain with reset value 1. It will be reused by the TX CTS path.
- The timer, majority voter and FSM stay in uart_rx_ovs.

Test Plan:
1. 8N1 frame, L=16, LSB-first 0xA5 -> exactly one o_rx_valid, 153 cycles after the first START cycle; o_rx_data=0x0A5; all flags 0.
2. 7E2 frame, L=10, MSB-first 0x5A with a corrupted parity bit -> o_rx_data=0x05A, o_rx_parity_error=1, o_rx_frame_error=0; strobe appears only after the STOP2 decision.
3. rx low glitch of 3 clocks, L=16 -> no o_rx_started, no o_rx_valid; returns to IDLE. A single-clock 1-glitch at count H-1 of a data bit is outvoted.
4. Line held low for 20 bit times, 8N1 -> one o_rx_valid with data 0x000, frame_error=1, break=1. No second strobe until rx returns high, then a valid 0x3C frame is received cleanly.
5. i_enable dropped in the middle of DATA, then reasserted before the next frame -> no strobe for the aborted frame; the next frame 0xFF is received correctly.
6. 9-bit data, odd parity, i_bit_length=2 (clamped to 4), value 0x1FF -> o_rx_data=0x1FF, parity_error=0; latency = 11*4+2+1 = 47 cycles.
